// File: rtl/proc_trace_buffer.sv
// rtl/proc_trace_buffer.sv - circular commit-trace capture buffer with cycle stamps and FWFT dequeue
// Config macro: PROC_TRACE_BUF_STOP_ON_FULL_EN (defined = drop new records when full, undefined = overwrite oldest)
module proc_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trace_val,
  input  logic [31:0]              trace_addr,
  input  logic [31:0]              trace_data,
  input  logic                     clear,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output logic [31:0]              deq_addr,
  output logic [31:0]              deq_data,
  output logic [CW-1:0]            deq_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  // Record storage; contents are meaningless until written, so it is not reset
  logic [31:0]   r_mem_addr  [DEPTH];
  logic [31:0]   r_mem_data  [DEPTH];
  logic [CW-1:0] r_mem_cycle [DEPTH];

  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [CW-1:0] r_cyc;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_lost;
  logic w_push;
  logic w_rp_adv;
  logic w_inc;
  logic w_dec;

  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);

  // A pop can only happen when a record is actually presented
  assign w_pop  = !w_empty && deq_rdy;

  // A record arriving at a full buffer with nothing leaving costs us history
  assign w_lost = trace_val && w_full && !w_pop;

`ifdef PROC_TRACE_BUF_STOP_ON_FULL_EN
  // Stop mode: the incoming record is discarded, the stored history is kept
  assign w_push   = trace_val && !w_lost;
  assign w_rp_adv = w_pop;
`else
  // Wrap mode: the incoming record replaces the oldest, which is dropped by advancing rp
  assign w_push   = trace_val;
  assign w_rp_adv = w_pop || w_lost;
`endif

  // Occupancy only moves on an unmatched push or pop; an overwrite keeps it at DEPTH
  assign w_inc = w_push && !w_pop && !w_lost;
  assign w_dec = w_pop && !w_push;

  // Free-running cycle stamp, deliberately untouched by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
    end else begin
      r_cyc <= r_cyc + CW'(1);
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping; clear wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_rp_adv) begin
        r_rp <= r_rp + AW'(1);
      end
      if (w_inc) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_dec) begin
        r_count <= r_count - (AW+1)'(1);
      end
      if (w_lost) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Record write at wp; a record presented alongside clear is dropped
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem_addr[r_wp]  <= trace_addr;
      r_mem_data[r_wp]  <= trace_data;
      r_mem_cycle[r_wp] <= r_cyc;
    end
  end

  // First-word-fall-through view of the oldest record, zeroed while empty
  always_comb begin
    deq_val   = !w_empty;
    deq_addr  = '0;
    deq_data  = '0;
    deq_cycle = '0;
    if (!w_empty) begin
      deq_addr  = r_mem_addr[r_rp];
      deq_data  = r_mem_data[r_rp];
      deq_cycle = r_mem_cycle[r_rp];
    end
  end

  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_proc_trace_buffer.sv
// tb/tb_proc_trace_buffer.sv - directed self-checking bench for proc_trace_buffer
module tb_proc_trace_buffer;

  logic        clk;
  logic        rst_n;
  logic        trace_val;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        clear;
  logic        deq_val;
  logic        deq_rdy;
  logic [31:0] deq_addr;
  logic [31:0] deq_data;
  logic [15:0] deq_cycle;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_cyc;
  logic [15:0] exp_stamp [40];
  logic [15:0] stamp_after_clear;
  logic [31:0] last_pop;

`ifdef PROC_TRACE_BUF_STOP_ON_FULL_EN
  localparam logic [31:0] FIRST_AFTER_OVF = 32'd0;
  localparam logic [31:0] LAST_AFTER_OVF  = 32'd15;
`else
  localparam logic [31:0] FIRST_AFTER_OVF = 32'd1;
  localparam logic [31:0] LAST_AFTER_OVF  = 32'd16;
`endif

  proc_trace_buffer #(.DEPTH(16), .CW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trace_val  (trace_val),
    .trace_addr (trace_addr),
    .trace_data (trace_data),
    .clear      (clear),
    .deq_val    (deq_val),
    .deq_rdy    (deq_rdy),
    .deq_addr   (deq_addr),
    .deq_data   (deq_data),
    .deq_cycle  (deq_cycle),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: zero out of reset, +1 per clock, ignores clear
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cyc <= '0;
    else        m_cyc <= m_cyc + 16'd1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    trace_val  = 1'b1;
    trace_addr = a;
    trace_data = d;
    tick();
    trace_val  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; trace_val = 1'b0; trace_addr = '0; trace_data = '0;
    clear = 1'b0; deq_rdy = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_deq_val", deq_val, 0);
    chk("rst_deq_addr", deq_addr, 0);
    chk("rst_deq_data", deq_data, 0);
    chk("rst_deq_cycle", deq_cycle, 0);

    // Basic capture: push during the cycle where cyc == 2
    rst_n = 1'b1;
    tick();
    tick();
    push(32'h200, 32'h5);
    chk("basic_deq_val", deq_val, 1);
    chk("basic_deq_addr", deq_addr, 32'h200);
    chk("basic_deq_data", deq_data, 32'h5);
    chk("basic_deq_cycle", deq_cycle, 2);
    chk("basic_count", count, 1);
    tick();
    chk("basic_hold_data", deq_data, 32'h5);
    chk("basic_hold_cycle", deq_cycle, 2);
    deq_rdy = 1'b1;
    tick();
    deq_rdy = 1'b0;
    chk("basic_pop_empty", empty, 1);
    chk("basic_pop_deq_val", deq_val, 0);
    chk("basic_pop_deq_addr", deq_addr, 0);

    // Streaming: one push and one pop per cycle
    deq_rdy = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        chk("stream_deq_val", deq_val, 1);
        chk("stream_deq_addr", deq_addr, 32'h200 + 4 * (i - 1));
        chk("stream_deq_data", deq_data, i - 1);
        chk("stream_deq_cycle", deq_cycle, exp_stamp[i-1]);
        if (i > 1) chk("stream_stamp_step", deq_cycle, exp_stamp[i-2] + 16'd1);
        chk("stream_count", count, 1);
      end
      if (i < 40) begin
        trace_val  = 1'b1;
        trace_addr = 32'h200 + 4 * i;
        trace_data = i;
        exp_stamp[i] = m_cyc;
      end else begin
        trace_val = 1'b0;
      end
      tick();
    end
    trace_val = 1'b0;
    deq_rdy   = 1'b0;
    chk("stream_end_empty", empty, 1);
    chk("stream_overflow", overflow, 0);

    // Fill past capacity with no pop
    for (int i = 0; i < 17; i++) push(32'h1000 + i, i);
    chk("ovf_count", count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_first_data", deq_data, FIRST_AFTER_OVF);
    deq_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      last_pop = deq_data;
      tick();
    end
    deq_rdy = 1'b0;
    chk("ovf_last_data", last_pop, LAST_AFTER_OVF);
    chk("ovf_drained_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);

    // Full boundary: simultaneous push and pop at DEPTH
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr1_overflow", overflow, 0);
    chk("clr1_count", count, 0);
    for (int i = 0; i < 16; i++) push(32'h3000 + i, 32'h20 + i);
    chk("bnd_full", full, 1);
    chk("bnd_overflow_pre", overflow, 0);
    chk("bnd_oldest", deq_data, 32'h20);
    trace_val = 1'b1; trace_addr = 32'h3099; trace_data = 32'h99;
    deq_rdy = 1'b1;
    tick();
    trace_val = 1'b0; deq_rdy = 1'b0;
    chk("bnd_count", count, 16);
    chk("bnd_overflow", overflow, 0);
    chk("bnd_next_data", deq_data, 32'h21);

    // Clear with five records held and a push in the same cycle
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h4000 + i, 32'h40 + i);
    chk("clr_pre_count", count, 5);
    clear = 1'b1; trace_val = 1'b1; trace_addr = 32'h4abc; trace_data = 32'hab;
    tick();
    clear = 1'b0; trace_val = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_deq_val", deq_val, 0);
    chk("clr_deq_data", deq_data, 0);
    stamp_after_clear = m_cyc;
    push(32'h5000, 32'h55);
    chk("clr_stamp_continues", deq_cycle, stamp_after_clear);
    chk("clr_data_after", deq_data, 32'h55);

    // Async reset between edges, with overflow set
    for (int i = 0; i < 16; i++) push(32'h6000 + i, i);
    chk("ar_pre_overflow", overflow, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_overflow", overflow, 0);
    chk("ar_deq_val", deq_val, 0);
    chk("ar_deq_addr", deq_addr, 0);
    chk("ar_deq_cycle", deq_cycle, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    push(32'h7000, 32'h77);
    chk("ar_restart_cycle", deq_cycle, 2);
    chk("ar_restart_data", deq_data, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
